// File: rtl/register_bank.sv
// 32 x WIDTH MIPS register file with registered A/B operand latches.
// Writes use a one-hot select; $zero is hard-wired and multi-hot writes are suppressed.
module register_bank #(
    parameter int          WIDTH    = 32,
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic [31:0]      write_onehot,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       read_addr1,
    input  logic [4:0]       read_addr2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    output logic             onehot_err
);

    localparam logic [WIDTH-1:0] SP_VALUE = WIDTH'(SP_RESET);

    logic [WIDTH-1:0] regs [32];
    logic [31:0]      sel;
    logic             multi;
    logic             write_ok;
    logic [WIDTH-1:0] read_next1;
    logic [WIDTH-1:0] read_next2;

    // A single surviving bit means a legal write; clearing the lowest set bit detects any extra one.
    always_comb begin
        sel      = write_onehot & 32'hFFFF_FFFE;
        multi    = |(sel & (sel - 32'd1));
        write_ok = reg_write && (sel != 32'd0) && !multi;
    end

    always_comb begin
        read_next1 = '0;
        read_next2 = '0;
        if (read_addr1 != 5'd0) begin
            read_next1 = (write_ok && sel[read_addr1]) ? write_data : regs[read_addr1];
        end
        if (read_addr2 != 5'd0) begin
            read_next2 = (write_ok && sel[read_addr2]) ? write_data : regs[read_addr2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= (k == SP_INDEX) ? SP_VALUE : '0;
            end
            read_data1 <= '0;
            read_data2 <= '0;
            onehot_err <= 1'b0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (write_ok && sel[k]) begin
                    regs[k] <= write_data;
                end
            end
            read_data1 <= read_next1;
            read_data2 <= read_next2;
            if (reg_write && multi) begin
                onehot_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset image, writes, bypass,
// $zero handling, multi-hot suppression and asynchronous reset during a write.
module tb_register_bank;

    localparam logic [31:0] SP_RESET = 32'h7FFF_EFFC;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [31:0] write_onehot;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        onehot_err;

    int checks;
    int errors;

    register_bank #(
        .WIDTH(32),
        .SP_INDEX(29),
        .SP_RESET(SP_RESET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reg_write(reg_write),
        .write_onehot(write_onehot),
        .write_data(write_data),
        .read_addr1(read_addr1),
        .read_addr2(read_addr2),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .onehot_err(onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic rw, input logic [31:0] oh, input logic [31:0] wd,
                                 input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        reg_write    = rw;
        write_onehot = oh;
        write_data   = wd;
        read_addr1   = a1;
        read_addr2   = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        reg_write    = 1'b0;
        write_onehot = 32'd0;
        write_data   = 32'd0;
        read_addr1   = 5'd0;
        read_addr2   = 5'd0;

        // Reset held across edges: outputs forced to zero
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rd1", read_data1, 32'd0);
        checkOutput("rst_rd2", read_data2, 32'd0);
        checkOutput("rst_err", {31'd0, onehot_err}, 32'd0);

        @(negedge clk);
        reset = 1'b1;

        // Whole reset image through both ports: only $sp is non-zero
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 5'(i), 5'(i + 16));
            tick();
            checkOutput($sformatf("img_r%0d", i), read_data1, (i == 29) ? SP_RESET : 32'd0);
            checkOutput($sformatf("img_r%0d", i + 16), read_data2, (i + 16 == 29) ? SP_RESET : 32'd0);
        end
        checkOutput("img_err", {31'd0, onehot_err}, 32'd0);

        // Write reg8, read it back the following cycle
        applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 5'd0);
        tick();
        checkOutput("wr8_rd1_zero", read_data1, 32'd0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0BAD_F00D, 5'd8, 5'd0);
        tick();
        checkOutput("rd8", read_data1, 32'hDEAD_BEEF);

        // Same-edge write-first bypass on port 2, port 1 still sees reg8
        applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 5'd8, 5'd5);
        tick();
        checkOutput("byp5_rd2", read_data2, 32'h1234_5678);
        checkOutput("byp5_rd1", read_data1, 32'hDEAD_BEEF);

        // Write to $zero is ignored and raises no error
        applyStimulus(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        tick();
        checkOutput("zero_rd1", read_data1, 32'd0);
        checkOutput("zero_rd2", read_data2, 32'd0);
        checkOutput("zero_err", {31'd0, onehot_err}, 32'd0);

        // Seed reg1/reg2, then a multi-hot write must neither commit nor bypass
        applyStimulus(1'b1, 32'h0000_0002, 32'h1111_1111, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 32'h0000_0004, 32'h2222_2222, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 32'h0000_0006, 32'hAAAA_AAAA, 5'd1, 5'd2);
        tick();
        checkOutput("multi_rd1", read_data1, 32'h1111_1111);
        checkOutput("multi_rd2", read_data2, 32'h2222_2222);
        checkOutput("multi_err", {31'd0, onehot_err}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd1, 5'd2);
        tick();
        checkOutput("multi_hold_rd1", read_data1, 32'h1111_1111);
        checkOutput("multi_hold_rd2", read_data2, 32'h2222_2222);
        checkOutput("multi_sticky", {31'd0, onehot_err}, 32'd1);

        // Reset asserted between write setup and the edge aborts the write
        applyStimulus(1'b1, 32'h0000_0008, 32'h5555_5555, 5'd3, 5'd3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rd1", read_data1, 32'd0);
        checkOutput("async_err", {31'd0, onehot_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b1;
        reg_write    = 1'b0;
        write_onehot = 32'h0000_0006;
        read_addr1   = 5'd3;
        read_addr2   = 5'd29;
        tick();
        checkOutput("abort_rd1", read_data1, 32'd0);
        checkOutput("abort_sp", read_data2, SP_RESET);
        checkOutput("nowrite_multi_err", {31'd0, onehot_err}, 32'd0);

        // Bit 0 alongside one real bit is still a legal single write
        applyStimulus(1'b1, 32'h0000_0003, 32'h0000_0033, 5'd1, 5'd8);
        tick();
        checkOutput("bit0_byp", read_data1, 32'h0000_0033);
        checkOutput("post_rst_r8", read_data2, 32'd0);
        checkOutput("bit0_err", {31'd0, onehot_err}, 32'd0);

        // Top register, bypass on both ports addressing the same index
        applyStimulus(1'b1, 32'h8000_0000, 32'hCAFE_0031, 5'd31, 5'd31);
        tick();
        checkOutput("r31_rd1", read_data1, 32'hCAFE_0031);
        checkOutput("r31_rd2", read_data2, 32'hCAFE_0031);
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd31, 5'd1);
        tick();
        checkOutput("r31_hold", read_data1, 32'hCAFE_0031);
        checkOutput("r1_hold", read_data2, 32'h0000_0033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
